// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage decode, branch/jump resolution and hazard control for the 5-stage MIPS pipeline
module id_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter int CNT_W      = 16,
  parameter int EN_JAL     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  equal,
  input  logic                  hold_in,
  output logic [1:0]            pc_src,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  if_flush,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_sel,
  output logic                  ex_link,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [REG_ADDR_W-1:0] LINK_REG = {REG_ADDR_W{1'b1}};
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  logic [5:0]            opcode;
  logic [5:0]            func;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic                  unused_shamt;

  assign opcode       = instruction[31:26];
  assign func         = instruction[5:0];
  assign rs           = REG_ADDR_W'(instruction[25:21]);
  assign rt           = REG_ADDR_W'(instruction[20:16]);
  assign rd           = REG_ADDR_W'(instruction[15:11]);
  assign unused_shamt = ^instruction[10:6];

  logic                  d_reg_write;
  logic                  d_mem_read;
  logic                  d_mem_write;
  logic                  d_mem_to_reg;
  logic                  d_alu_sel;
  logic                  d_link;
  logic [ALUOP_W-1:0]    d_alu_op;
  logic [REG_ADDR_W-1:0] d_dest;
  logic                  d_illegal;
  logic                  use_rs;
  logic                  use_rt;
  logic                  is_beq;
  logic                  is_bne;
  logic                  is_jump;

  always_comb begin
    d_reg_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_sel    = 1'b0;
    d_link       = 1'b0;
    d_alu_op     = '0;
    d_dest       = '0;
    d_illegal    = 1'b0;
    use_rs       = 1'b0;
    use_rt       = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_jump      = 1'b0;
    case (opcode)
      OP_LW: begin
        d_reg_write  = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_alu_sel    = 1'b1;
        d_dest       = rt;
        use_rs       = 1'b1;
      end
      OP_SW: begin
        d_mem_write = 1'b1;
        d_alu_sel   = 1'b1;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
      end
      OP_ADDI: begin
        d_reg_write = 1'b1;
        d_alu_sel   = 1'b1;
        d_dest      = rt;
        use_rs      = 1'b1;
      end
      OP_RTYPE: begin
        // Five ALU functions share one path; anything else except nop is illegal
        if (func != FN_NOP) begin
          d_reg_write = 1'b1;
          d_dest      = rd;
          use_rs      = 1'b1;
          use_rt      = 1'b1;
          case (func)
            FN_ADDU: d_alu_op = ALUOP_W'(0);
            FN_SUBU: d_alu_op = ALUOP_W'(1);
            FN_AND:  d_alu_op = ALUOP_W'(2);
            FN_OR:   d_alu_op = ALUOP_W'(3);
            FN_SLTU: d_alu_op = ALUOP_W'(4);
            default: begin
              d_reg_write = 1'b0;
              d_dest      = '0;
              use_rs      = 1'b0;
              use_rt      = 1'b0;
              d_illegal   = 1'b1;
            end
          endcase
        end
      end
      OP_BEQ: begin
        is_beq = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J: is_jump = 1'b1;
      OP_JAL: begin
        if (EN_JAL != 0) begin
          is_jump     = 1'b1;
          d_reg_write = 1'b1;
          d_link      = 1'b1;
          d_dest      = LINK_REG;
        end else begin
          d_illegal = 1'b1;
        end
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic                  mem_load;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  load_use;
  logic                  branch_haz;
  logic                  stall;
  logic                  advance;
  logic                  taken;

  always_comb begin
    load_use = ex_mem_read && (ex_dest != ZERO_REG) &&
               ((use_rs && (ex_dest == rs)) || (use_rt && (ex_dest == rt)));
    // Branches compare in ID, so they must also wait for a load still in MEM
    branch_haz = (is_beq || is_bne) &&
                 ((ex_reg_write && (ex_dest != ZERO_REG) && ((ex_dest == rs) || (ex_dest == rt))) ||
                  (mem_load && (mem_dest != ZERO_REG) && ((mem_dest == rs) || (mem_dest == rt))));
    stall   = load_use || branch_haz;
    advance = !hold_in && !stall;
    taken   = (is_beq && equal) || (is_bne && !equal);
  end

  always_comb begin
    pc_write   = advance;
    ifid_write = advance;
    pc_src     = 2'd0;
    if_flush   = 1'b0;
    if (advance) begin
      if (is_jump) begin
        pc_src   = 2'd2;
        if_flush = 1'b1;
      end else if (taken) begin
        pc_src   = 2'd1;
        if_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_sel    <= 1'b0;
      ex_link       <= 1'b0;
      ex_alu_op     <= '0;
      ex_dest       <= '0;
      illegal_op    <= 1'b0;
      mem_load      <= 1'b0;
      mem_dest      <= '0;
      stall_cnt     <= '0;
    end else if (hold_in) begin
      illegal_op <= 1'b0;
    end else begin
      mem_load <= ex_mem_read;
      mem_dest <= ex_dest;
      if (stall) begin
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_alu_sel    <= 1'b0;
        ex_link       <= 1'b0;
        ex_alu_op     <= '0;
        ex_dest       <= '0;
        illegal_op    <= 1'b0;
        if (stall_cnt != {CNT_W{1'b1}}) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        ex_reg_write  <= d_reg_write;
        ex_mem_read   <= d_mem_read;
        ex_mem_write  <= d_mem_write;
        ex_mem_to_reg <= d_mem_to_reg;
        ex_alu_sel    <= d_alu_sel;
        ex_link       <= d_link;
        ex_alu_op     <= d_alu_op;
        ex_dest       <= d_dest;
        illegal_op    <= d_illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - randomized bench for id_hazard_ctrl against a mnemonic-level pipeline model
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        equal;
  logic        hold_in;

  logic [1:0][1:0] pc_src;
  logic [1:0]      pc_write, ifid_write, if_flush;
  logic [1:0]      ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_sel, ex_link;
  logic [1:0][2:0] ex_alu_op;
  logic [1:0][4:0] ex_dest;
  logic [1:0]      illegal_op;
  logic [15:0]     cnt0;
  logic [1:0]      cnt1;

  always #5 clk = ~clk;

  id_hazard_ctrl u0 (
    .clk(clk), .rst(rst), .instruction(instruction), .equal(equal), .hold_in(hold_in),
    .pc_src(pc_src[0]), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .if_flush(if_flush[0]),
    .ex_reg_write(ex_reg_write[0]), .ex_mem_read(ex_mem_read[0]), .ex_mem_write(ex_mem_write[0]),
    .ex_mem_to_reg(ex_mem_to_reg[0]), .ex_alu_sel(ex_alu_sel[0]), .ex_link(ex_link[0]),
    .ex_alu_op(ex_alu_op[0]), .ex_dest(ex_dest[0]), .illegal_op(illegal_op[0]), .stall_cnt(cnt0)
  );

  id_hazard_ctrl #(.CNT_W(2), .EN_JAL(0)) u1 (
    .clk(clk), .rst(rst), .instruction(instruction), .equal(equal), .hold_in(hold_in),
    .pc_src(pc_src[1]), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .if_flush(if_flush[1]),
    .ex_reg_write(ex_reg_write[1]), .ex_mem_read(ex_mem_read[1]), .ex_mem_write(ex_mem_write[1]),
    .ex_mem_to_reg(ex_mem_to_reg[1]), .ex_alu_sel(ex_alu_sel[1]), .ex_link(ex_link[1]),
    .ex_alu_op(ex_alu_op[1]), .ex_dest(ex_dest[1]), .illegal_op(illegal_op[1]), .stall_cnt(cnt1)
  );

  typedef enum {K_NOP, K_R, K_LW, K_SW, K_ADDI, K_BEQ, K_BNE, K_J, K_JAL, K_BAD} kind_t;

  typedef struct {
    bit rw, mr, mw, m2r, asel, link;
    int op;
    int dest;
  } bundle_t;

  int checks = 0;
  int failures = 0;

  bundle_t m_ex[2];
  bit      m_ill[2];
  bit      m_mload[2];
  int      m_mdest[2];
  int      m_cnt[2];
  int      cnt_max[2] = '{65535, 3};
  bit      en_jal[2]  = '{1'b1, 1'b0};
  int      alu_funcs[5] = '{33, 35, 36, 37, 43};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [31:0] i, input bit jal_ok);
    int op, fn;
    op = int'(i[31:26]);
    fn = int'(i[5:0]);
    case (op)
      35: return K_LW;
      43: return K_SW;
      8:  return K_ADDI;
      4:  return K_BEQ;
      5:  return K_BNE;
      2:  return K_J;
      3:  return jal_ok ? K_JAL : K_BAD;
      0: begin
        if (fn == 0) return K_NOP;
        foreach (alu_funcs[n]) if (alu_funcs[n] == fn) return K_R;
        return K_BAD;
      end
      default: return K_BAD;
    endcase
  endfunction

  function automatic bundle_t bundle_of(input kind_t k, input logic [31:0] i);
    bundle_t b;
    b = '{default: 0};
    case (k)
      K_LW:   begin b.rw = 1; b.mr = 1; b.m2r = 1; b.asel = 1; b.dest = int'(i[20:16]); end
      K_SW:   begin b.mw = 1; b.asel = 1; end
      K_ADDI: begin b.rw = 1; b.asel = 1; b.dest = int'(i[20:16]); end
      K_R: begin
        b.rw = 1;
        b.dest = int'(i[15:11]);
        foreach (alu_funcs[n]) if (alu_funcs[n] == int'(i[5:0])) b.op = n;
      end
      K_JAL:  begin b.rw = 1; b.link = 1; b.dest = 31; end
      default: ;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] mk_r(input int s, input int t, input int d, input int fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int s, input int t, input int imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '{default: 0};
      m_ill[k] = 0; m_mload[k] = 0; m_mdest[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic step(input logic [31:0] ins, input bit eq, input bit hold, input bit rs_t);
    @(negedge clk);
    instruction = ins; equal = eq; hold_in = hold; rst = rs_t;
    #1;
    for (int k = 0; k < 2; k++) begin
      kind_t   kd;
      int      srcs[$];
      bit      lu, bh, stl, br, tk, jmp;
      int      e_src, e_pcw, e_flush, got_cnt;
      bundle_t nb;
      kd = classify(ins, en_jal[k]);
      if (kd inside {K_R, K_LW, K_SW, K_ADDI, K_BEQ, K_BNE} && ins[25:21] != 0) srcs.push_back(int'(ins[25:21]));
      if (kd inside {K_R, K_SW, K_BEQ, K_BNE} && ins[20:16] != 0) srcs.push_back(int'(ins[20:16]));
      br = kd inside {K_BEQ, K_BNE};
      lu = 0; bh = 0;
      foreach (srcs[n]) begin
        if (m_ex[k].mr && srcs[n] == m_ex[k].dest) lu = 1;
        if (br && m_ex[k].rw && srcs[n] == m_ex[k].dest) bh = 1;
        if (br && m_mload[k] && srcs[n] == m_mdest[k]) bh = 1;
      end
      stl = lu || bh;
      tk  = (kd == K_BEQ && eq) || (kd == K_BNE && !eq);
      jmp = kd inside {K_J, K_JAL};
      e_pcw = (!hold && !stl) ? 1 : 0;
      e_src = 0; e_flush = 0;
      if (e_pcw == 1 && jmp) begin e_src = 2; e_flush = 1; end
      else if (e_pcw == 1 && tk) begin e_src = 1; e_flush = 1; end

      check($sformatf("u%0d.pc_src", k), int'(pc_src[k]), e_src);
      check($sformatf("u%0d.pc_write", k), int'(pc_write[k]), e_pcw);
      check($sformatf("u%0d.ifid_write", k), int'(ifid_write[k]), e_pcw);
      check($sformatf("u%0d.if_flush", k), int'(if_flush[k]), e_flush);
      check($sformatf("u%0d.ex_reg_write", k), int'(ex_reg_write[k]), int'(m_ex[k].rw));
      check($sformatf("u%0d.ex_mem_read", k), int'(ex_mem_read[k]), int'(m_ex[k].mr));
      check($sformatf("u%0d.ex_mem_write", k), int'(ex_mem_write[k]), int'(m_ex[k].mw));
      check($sformatf("u%0d.ex_mem_to_reg", k), int'(ex_mem_to_reg[k]), int'(m_ex[k].m2r));
      check($sformatf("u%0d.ex_alu_sel", k), int'(ex_alu_sel[k]), int'(m_ex[k].asel));
      check($sformatf("u%0d.ex_link", k), int'(ex_link[k]), int'(m_ex[k].link));
      check($sformatf("u%0d.ex_alu_op", k), int'(ex_alu_op[k]), m_ex[k].op);
      check($sformatf("u%0d.ex_dest", k), int'(ex_dest[k]), m_ex[k].dest);
      check($sformatf("u%0d.illegal_op", k), int'(illegal_op[k]), int'(m_ill[k]));
      got_cnt = (k == 0) ? int'(cnt0) : int'(cnt1);
      check($sformatf("u%0d.stall_cnt", k), got_cnt, m_cnt[k]);

      if (rs_t) begin
        m_ex[k] = '{default: 0};
        m_ill[k] = 0; m_mload[k] = 0; m_mdest[k] = 0; m_cnt[k] = 0;
      end else if (hold) begin
        m_ill[k] = 0;
      end else begin
        m_mload[k] = m_ex[k].mr;
        m_mdest[k] = m_ex[k].dest;
        if (stl) begin
          m_ex[k] = '{default: 0};
          m_ill[k] = 0;
          if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
        end else begin
          nb = bundle_of(kd, ins);
          m_ex[k] = nb;
          m_ill[k] = (kd == K_BAD);
        end
      end
    end
  endtask

  logic [31:0] nop_i = 32'd0;

  initial begin
    rst = 1'b1; instruction = '0; equal = 1'b0; hold_in = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // lw $2,0($1); add $3,$2,$4
    step(mk_i(35, 1, 2, 0), 0, 0, 0);
    step(mk_r(2, 4, 3, 33), 0, 0, 0);
    step(mk_r(2, 4, 3, 33), 0, 0, 0);
    step(nop_i, 0, 0, 0);
    // lw $5; beq $5,$6 taken after two stalls
    step(mk_i(35, 0, 5, 4), 0, 0, 0);
    repeat (3) step(mk_i(4, 5, 6, 8), 1, 0, 0);
    // add $7; bne $7,$0 then the same on $0
    step(mk_r(1, 2, 7, 33), 0, 0, 0);
    repeat (2) step(mk_i(5, 7, 0, 3), 0, 0, 0);
    step(mk_r(1, 2, 0, 33), 0, 0, 0);
    step(mk_i(5, 0, 0, 3), 0, 0, 0);
    // jal, then j
    step({6'd3, 26'h12345}, 0, 0, 0);
    step({6'd2, 26'h00abc}, 0, 0, 0);
    // hold during a load-use stall
    step(mk_i(35, 0, 9, 0), 0, 0, 0);
    repeat (3) step(mk_r(9, 9, 10, 37), 0, 1, 0);
    repeat (2) step(mk_r(9, 9, 10, 37), 0, 0, 0);
    // illegal opcode, illegal func
    step({6'b111111, 26'h0}, 0, 0, 0);
    step(nop_i, 0, 0, 0);
    step(mk_r(1, 2, 3, 32), 0, 0, 0);
    step(nop_i, 0, 0, 0);
    // reset asserted mid-stall
    step(mk_i(35, 0, 2, 0), 0, 0, 0);
    step(mk_r(2, 2, 3, 36), 0, 0, 1);
    step(mk_r(2, 2, 3, 36), 0, 0, 0);
    // five load-use stalls saturate the 2-bit counter
    for (int n = 0; n < 5; n++) begin
      step(mk_i(35, 0, 4, 0), 0, 0, 0);
      step(mk_r(4, 1, 5, 35), 0, 0, 0);
    end
    step(nop_i, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      int s, t, d;
      s = $urandom_range(0, 3); t = $urandom_range(0, 3); d = $urandom_range(0, 3);
      case ($urandom_range(0, 10))
        0: ins = nop_i;
        1, 2: ins = mk_r(s, t, d, alu_funcs[$urandom_range(0, 4)]);
        3: ins = mk_i(35, s, t, $urandom_range(0, 255));
        4: ins = mk_i(43, s, t, $urandom_range(0, 255));
        5: ins = mk_i(8, s, t, $urandom_range(0, 255));
        6: ins = mk_i(4, s, t, 2);
        7: ins = mk_i(5, s, t, 2);
        8: ins = {6'd2 + 6'($urandom_range(0, 1)), 26'($urandom)};
        9: ins = mk_r(s, t, d, $urandom_range(0, 63));
        default: ins = $urandom;
      endcase
      step(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
